level_ctrl: RTL and testbench
=============================

LEVEL_CTRL -- requirements
Module: level_ctrl

Interface
REQ-001 SHALL have parameter LINES_PER_LEVEL, default 10: cleared lines per level step.
REQ-002 SHALL have parameter LEVEL_MAX, default 15: highest level; fits the 4-bit level_o.
REQ-003 SHALL have parameter SCORE_W, default 24: score width in bits.
REQ-004 SHALL have port clk, input, 1: sole clock; all state on posedge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port new_game_i, input, 1: synchronous clear of all game state.
REQ-007 SHALL have port lines_valid_i, input, 1: single-cycle strobe reporting a clear event.
REQ-008 SHALL have port lines_cnt_i, input, 3: lines cleared in the event, qualified by lines_valid_i.
REQ-009 SHALL have port busy_o, output, 1: an event is being processed.
REQ-010 SHALL have port level_o, output, 4: current level.
REQ-011 SHALL have port lines_total_o, output, 16: total lines cleared this game.
REQ-012 SHALL have port score_o, output, SCORE_W: current score.
REQ-013 SHALL have port score_upd_o, output, 1: one-cycle pulse after each committed event.
REQ-014 SHALL have port level_changed_o, output, 1: one-cycle pulse on a level increment; drives the gravity-tick generator's level-change input.

Function
REQ-015 SHALL implement FSM IDLE -> MUL -> COMMIT -> IDLE, with busy_o = (state != IDLE).
REQ-016 SHALL accept an event only in IDLE, with lines_valid_i=1 and lines_cnt_i!=0; lines_valid_i in other states is dropped (no queue); lines_cnt_i=0 is ignored with no state change.
REQ-017 SHALL treat lines_cnt_i values 5..7 as 4.
REQ-018 SHALL latch base points on acceptance: 1->40, 2->100, 3->300, 4->1200.
REQ-019 SHALL compute points = base*(level_o+1) in MUL by serial shift-add over the 4 level bits, exactly 4 cycles, using level_o as held at acceptance.
REQ-020 SHALL sequence timing from acceptance edge E0: MUL for edges E1..E4, COMMIT updates registers on edge E5, IDLE from E5 onward.
REQ-021 SHALL accept a new event at edge E6 at the earliest.
REQ-022 SHALL, at the COMMIT edge, add points to score_o, saturating at 2^SCORE_W-1.
REQ-023 SHALL, at the COMMIT edge, add the clamped line count to lines_total_o, saturating at 16'hFFFF.
REQ-024 SHALL, at the COMMIT edge, add the clamped line count to an internal lines_in_level counter.
REQ-025 SHALL handle level crossing at COMMIT: if lines_in_level+n >= LINES_PER_LEVEL, lines_in_level becomes (sum - LINES_PER_LEVEL).
REQ-026 SHALL, on a crossing with level_o < LEVEL_MAX, increment level_o and assert level_changed_o.
REQ-027 SHALL, on a crossing at LEVEL_MAX, leave level_o unchanged with no pulse.
REQ-028 SHALL advance at most one level per event, since the 4-line maximum is below LINES_PER_LEVEL.
REQ-029 SHALL assert score_upd_o for exactly the one cycle following E5, and level_changed_o, when set, in that same cycle.
REQ-030 SHALL give new_game_i priority over any event: state->IDLE, all counters and outputs cleared, in-flight computation aborted, no pulses.
REQ-031 SHALL ignore a lines_valid_i that coincides with new_game_i.

Reset
REQ-032 SHALL, while rst_i=1 regardless of clk, force state=IDLE and busy_o=0.
REQ-033 SHALL, while rst_i=1 regardless of clk, force level_o=0, lines_total_o=0 and score_o=0.
REQ-034 SHALL, while rst_i=1 regardless of clk, force lines_in_level=0, score_upd_o=0 and level_changed_o=0.
REQ-035 SHALL, when rst_i asserts mid-MUL, discard the pending event with no pulse after release.
REQ-036 SHALL resume on the first clk edge after rst_i deasserts.

Verification
REQ-037 SHALL cover reset with rst_i pulsed between edges -> all outputs 0 immediately, busy_o=0.
REQ-038 SHALL cover a single-line event at level 0 -> busy_o high 5 cycles, then score_o=40, lines_total_o=1, score_upd_o one cycle, level_changed_o=0.
REQ-039 SHALL cover ten single-line events then lines_cnt_i=4 -> after the 10th, level_o=1 with one level_changed_o pulse; after the 4-line event, score_o=2800, lines_total_o=14, no pulse.
REQ-040 SHALL cover repeated 4-line events until level_o=15, then more -> exactly 15 level_changed_o pulses total, level_o holds 15.
REQ-041 SHALL cover lines_valid_i during busy_o and lines_cnt_i=0 in IDLE -> both ignored, score_o unchanged, no score_upd_o.
REQ-042 SHALL cover new_game_i at E2 and rst_i in a separate mid-MUL run -> IDLE, all outputs 0, no pulses, next event scores from 0.

Source files
------------

// File: rtl/level_ctrl.sv
// level_ctrl: scoring, line-count and level bookkeeping for a falling-block game.
// A line-clear event is accepted in IDLE. The points, base * (level + 1), are
// worked out by a 4-cycle serial shift-add. All counters update together on
// the COMMIT edge.
//
// Ports:
//   clk             : clock, all state updates on posedge
//   rst_i           : asynchronous active-high reset
//   new_game_i      : synchronous clear of all game state (highest priority)
//   lines_valid_i   : single-cycle strobe for a clear event
//   lines_cnt_i     : lines cleared in the event (5..7 clamp to 4)
//   busy_o          : an event is in flight
//   level_o         : current level
//   lines_total_o   : lines cleared this game (saturating)
//   score_o         : current score (saturating)
//   score_upd_o     : one-cycle pulse after each committed event
//   level_changed_o : one-cycle pulse when the level increments
module level_ctrl #(
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned LEVEL_MAX       = 15,
  parameter int unsigned SCORE_W         = 24
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               new_game_i,
  input  logic               lines_valid_i,
  input  logic [2:0]         lines_cnt_i,
  output logic               busy_o,
  output logic [3:0]         level_o,
  output logic [15:0]        lines_total_o,
  output logic [SCORE_W-1:0] score_o,
  output logic               score_upd_o,
  output logic               level_changed_o
);

  // Points never exceed 1200 * 16 = 19200, so 15 bits are enough.
  localparam int unsigned PTS_W  = 15;
  localparam int unsigned SUM_W  = ((SCORE_W > PTS_W) ? SCORE_W : PTS_W) + 1;
  // lines_in_level + n is at most LINES_PER_LEVEL + 3.
  localparam int unsigned LIL_W  = $clog2(LINES_PER_LEVEL + 5);
  localparam logic [SCORE_W-1:0] SCORE_SAT = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        step;
  logic [PTS_W-1:0]  mcand;
  logic [PTS_W-1:0]  acc;
  logic [3:0]        lvl_sh;
  logic [2:0]        n_lat;
  logic [LIL_W-1:0]  lines_in_level;

  logic [2:0]         n_clamp_c;
  logic [PTS_W-1:0]   base_c;
  logic               accept_c;
  logic [PTS_W-1:0]   acc_add_c;
  logic [SUM_W-1:0]   score_sum_c;
  logic [SCORE_W-1:0] score_next_c;
  logic [16:0]        total_sum_c;
  logic [15:0]        total_next_c;
  logic [LIL_W-1:0]   lil_sum_c;
  logic [LIL_W-1:0]   lil_next_c;
  logic               cross_c;
  logic               level_up_c;

  // Event decode: clamp the line count and look up the base points.
  always_comb begin
    n_clamp_c = (lines_cnt_i > 3'd4) ? 3'd4 : lines_cnt_i;
    accept_c  = lines_valid_i && (lines_cnt_i != 3'd0);
    case (n_clamp_c)
      3'd1:    base_c = PTS_W'(40);
      3'd2:    base_c = PTS_W'(100);
      3'd3:    base_c = PTS_W'(300);
      3'd4:    base_c = PTS_W'(1200);
      default: base_c = '0;
    endcase
  end

  // One shift-add step. The accumulator starts at base, which supplies the "+1" term.
  always_comb begin
    acc_add_c = acc + (lvl_sh[0] ? mcand : PTS_W'(0));
  end

  // Commit arithmetic with saturation and level-crossing detection.
  always_comb begin
    score_sum_c  = SUM_W'(score_o) + SUM_W'(acc);
    score_next_c = (score_sum_c > SUM_W'(SCORE_SAT)) ? SCORE_SAT
                                                     : SCORE_W'(score_sum_c);
    total_sum_c  = {1'b0, lines_total_o} + 17'(n_lat);
    total_next_c = total_sum_c[16] ? 16'hFFFF : total_sum_c[15:0];
    lil_sum_c    = lines_in_level + LIL_W'(n_lat);
    cross_c      = (lil_sum_c >= LIL_W'(LINES_PER_LEVEL));
    lil_next_c   = cross_c ? (lil_sum_c - LIL_W'(LINES_PER_LEVEL)) : lil_sum_c;
    level_up_c   = cross_c && (level_o < 4'(LEVEL_MAX));
  end

  // Control FSM and all registered state.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      step            <= '0;
      mcand           <= '0;
      acc             <= '0;
      lvl_sh          <= '0;
      n_lat           <= '0;
      lines_in_level  <= '0;
      busy_o          <= 1'b0;
      level_o         <= '0;
      lines_total_o   <= '0;
      score_o         <= '0;
      score_upd_o     <= 1'b0;
      level_changed_o <= 1'b0;
    end else begin
      score_upd_o     <= 1'b0;
      level_changed_o <= 1'b0;
      if (new_game_i) begin
        // New game overrides everything, including an event in flight.
        state          <= IDLE;
        step           <= '0;
        mcand          <= '0;
        acc            <= '0;
        lvl_sh         <= '0;
        n_lat          <= '0;
        lines_in_level <= '0;
        busy_o         <= 1'b0;
        level_o        <= '0;
        lines_total_o  <= '0;
        score_o        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept_c) begin
              state  <= MUL;
              busy_o <= 1'b1;
              step   <= '0;
              acc    <= base_c;
              mcand  <= base_c;
              lvl_sh <= level_o;
              n_lat  <= n_clamp_c;
            end
          end
          MUL: begin
            acc    <= acc_add_c;
            mcand  <= mcand << 1;
            lvl_sh <= lvl_sh >> 1;
            step   <= step + 2'd1;
            if (step == 2'd3) begin
              state <= COMMIT;
            end
          end
          COMMIT: begin
            score_o        <= score_next_c;
            lines_total_o  <= total_next_c;
            lines_in_level <= lil_next_c;
            score_upd_o    <= 1'b1;
            if (level_up_c) begin
              level_o         <= level_o + 4'd1;
              level_changed_o <= 1'b1;
            end
            state  <= IDLE;
            busy_o <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: directed self-checking bench for level_ctrl.
// Inputs change on negedge, and outputs are sampled on negedge.
module tb_level_ctrl;

  localparam int SCORE_W   = 24;
  localparam int SCORE_MAX = 16777215;

  logic               clk = 1'b0;
  logic               rst;
  logic               new_game;
  logic               lines_valid;
  logic [2:0]         lines_cnt;
  logic               busy;
  logic [3:0]         level;
  logic [15:0]        lines_total;
  logic [SCORE_W-1:0] score;
  logic               score_upd;
  logic               level_changed;

  int tests_run    = 0;
  int tests_failed = 0;
  int lc_pulses    = 0;

  int exp_score, exp_total, exp_level, exp_lil;

  level_ctrl #(
    .LINES_PER_LEVEL(10),
    .LEVEL_MAX      (15),
    .SCORE_W        (SCORE_W)
  ) dut (
    .clk            (clk),
    .rst_i          (rst),
    .new_game_i     (new_game),
    .lines_valid_i  (lines_valid),
    .lines_cnt_i    (lines_cnt),
    .busy_o         (busy),
    .level_o        (level),
    .lines_total_o  (lines_total),
    .score_o        (score),
    .score_upd_o    (score_upd),
    .level_changed_o(level_changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (level_changed === 1'b1) lc_pulses++;
  end

  function automatic int base_pts(input int n);
    case (n)
      1:       return 40;
      2:       return 100;
      3:       return 300;
      4:       return 1200;
      default: return 0;
    endcase
  endfunction

  // Reference bookkeeping for one committed event; returns the expected level pulse.
  function automatic int model_commit(input int cnt);
    int n;
    int lc;
    n  = (cnt > 4) ? 4 : cnt;
    lc = 0;
    exp_score = exp_score + base_pts(n) * (exp_level + 1);
    if (exp_score > SCORE_MAX) exp_score = SCORE_MAX;
    exp_total = exp_total + n;
    if (exp_total > 65535) exp_total = 65535;
    exp_lil = exp_lil + n;
    if (exp_lil >= 10) begin
      exp_lil = exp_lil - 10;
      if (exp_level < 15) begin
        exp_level = exp_level + 1;
        lc = 1;
      end
    end
    return lc;
  endfunction

  function automatic void model_clear();
    exp_score = 0;
    exp_total = 0;
    exp_level = 0;
    exp_lil   = 0;
  endfunction

  // Sends one event, checks the 5-cycle busy window, the commit values and the pulse width.
  task automatic do_event(input int cnt, input bit chk_busy);
    int lc;
    lc = model_commit(cnt);
    @(negedge clk);
    lines_valid = 1'b1;
    lines_cnt   = 3'(cnt);
    @(negedge clk);
    lines_valid = 1'b0;
    lines_cnt   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (chk_busy) begin
        tests_run++;
        if (busy !== 1'b1 || score_upd !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_window[%0d]: busy=%0b upd=%0b, expected busy=1 upd=0", k, busy, score_upd);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (busy !== 1'b0 || score_upd !== 1'b1 || level_changed !== 1'(lc)) begin
      tests_failed++;
      $display("FAIL commit_pulses: busy=%0b upd=%0b lc=%0b, expected 0 1 %0d", busy, score_upd, level_changed, lc);
    end
    tests_run++;
    if (score !== SCORE_W'(exp_score) || lines_total !== 16'(exp_total) || level !== 4'(exp_level)) begin
      tests_failed++;
      $display("FAIL commit_values: score=%0d total=%0d level=%0d, expected %0d %0d %0d",
               score, lines_total, level, exp_score, exp_total, exp_level);
    end
    @(negedge clk);
    tests_run++;
    if (score_upd !== 1'b0 || level_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL pulse_width: upd=%0b lc=%0b, expected 0 0", score_upd, level_changed);
    end
  endtask

  task automatic watch_quiet(input int cycles, input string name);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || score_upd !== 1'b0 || level_changed !== 1'b0 || score !== SCORE_W'(exp_score)) begin
        tests_failed++;
        $display("FAIL %s[%0d]: busy=%0b upd=%0b lc=%0b score=%0d, expected 0 0 0 %0d",
                 name, k, busy, score_upd, level_changed, score, exp_score);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    tests_run++;
    if (busy !== 1'b0 || level !== 4'd0 || lines_total !== 16'd0 || score !== '0 ||
        score_upd !== 1'b0 || level_changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: busy=%0b level=%0d total=%0d score=%0d upd=%0b lc=%0b, expected all 0",
               name, busy, level, lines_total, score, score_upd, level_changed);
    end
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_all_zero("new_game_clear");
  endtask

  task automatic test_reset();
    rst = 1'b1; new_game = 1'b0; lines_valid = 1'b0; lines_cnt = 3'd0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    do_event(1, 1'b1);
    tests_run++;
    if (score !== 24'd40 || lines_total !== 16'd1 || level !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_line: score=%0d total=%0d level=%0d, expected 40 1 0", score, lines_total, level);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("async_reset_between_edges");
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic test_level_up();
    lc_pulses = 0;
    for (int i = 0; i < 10; i++) do_event(1, 1'b0);
    tests_run++;
    if (level !== 4'd1 || lc_pulses != 1 || score !== 24'd400) begin
      tests_failed++;
      $display("FAIL level_up: level=%0d pulses=%0d score=%0d, expected 1 1 400", level, lc_pulses, score);
    end
    do_event(4, 1'b1);
    tests_run++;
    if (score !== 24'd2800 || lines_total !== 16'd14 || lc_pulses != 1) begin
      tests_failed++;
      $display("FAIL four_line_l1: score=%0d total=%0d pulses=%0d, expected 2800 14 1", score, lines_total, lc_pulses);
    end
  endtask

  task automatic test_ignored();
    int lc;
    lc = model_commit(1);
    @(negedge clk);
    lines_valid = 1'b1;
    lines_cnt   = 3'd1;
    @(negedge clk);
    lines_cnt   = 3'd4;  // held valid through E1..E5 must be dropped
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_drop[%0d]: busy=%0b expected 1", k, busy);
      end
      @(negedge clk);
    end
    lines_valid = 1'b0;
    lines_cnt   = 3'd0;
    tests_run++;
    if (score_upd !== 1'b1 || score !== SCORE_W'(exp_score) || level_changed !== 1'(lc)) begin
      tests_failed++;
      $display("FAIL drop_commit: upd=%0b score=%0d lc=%0b, expected 1 %0d %0d", score_upd, score, level_changed, exp_score, lc);
    end
    watch_quiet(3, "drop_no_second");
    @(negedge clk);
    lines_valid = 1'b1;
    lines_cnt   = 3'd0;
    @(negedge clk);
    lines_valid = 1'b0;
    watch_quiet(7, "zero_count");
  endtask

  task automatic test_clamp();
    int tot0;
    int lvl0;
    tot0 = exp_total;
    lvl0 = exp_level;
    do_event(7, 1'b1);
    tests_run++;
    if (lines_total !== 16'(tot0 + 4)) begin
      tests_failed++;
      $display("FAIL clamp_total: total=%0d expected %0d (level %0d)", lines_total, tot0 + 4, lvl0);
    end
  endtask

  task automatic test_new_game();
    @(negedge clk);
    lines_valid = 1'b1; lines_cnt = 3'd4;
    @(negedge clk);
    lines_valid = 1'b0; lines_cnt = 3'd0;
    @(negedge clk);
    new_game = 1'b1;  // seen at E2
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_all_zero("new_game_abort");
    watch_quiet(7, "new_game_quiet");
    @(negedge clk);
    lines_valid = 1'b1; lines_cnt = 3'd2; new_game = 1'b1;
    @(negedge clk);
    lines_valid = 1'b0; lines_cnt = 3'd0; new_game = 1'b0;
    check_all_zero("new_game_coincident");
    watch_quiet(6, "coincident_quiet");
    do_event(1, 1'b1);
    tests_run++;
    if (score !== 24'd40) begin
      tests_failed++;
      $display("FAIL after_new_game: score=%0d expected 40", score);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lines_valid = 1'b1; lines_cnt = 3'd3;
    @(negedge clk);
    lines_valid = 1'b0; lines_cnt = 3'd0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_all_zero("reset_mid_mul");
    #1 rst = 1'b0;
    model_clear();
    watch_quiet(8, "reset_mid_quiet");
    do_event(1, 1'b1);
    tests_run++;
    if (score !== 24'd40 || lines_total !== 16'd1) begin
      tests_failed++;
      $display("FAIL after_reset_mid: score=%0d total=%0d expected 40 1", score, lines_total);
    end
  endtask

  task automatic test_back_to_back();
    do_new_game();
    @(negedge clk);
    lines_valid = 1'b1; lines_cnt = 3'd1;
    @(negedge clk);
    lines_valid = 1'b0; lines_cnt = 3'd0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (score_upd !== 1'b1 || score !== 24'd40 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: upd=%0b score=%0d busy=%0b, expected 1 40 0", score_upd, score, busy);
    end
    lines_valid = 1'b1; lines_cnt = 3'd2;  // seen at E6
    @(negedge clk);
    lines_valid = 1'b0; lines_cnt = 3'd0;
    tests_run++;
    if (busy !== 1'b1 || score_upd !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_accept_e6: busy=%0b upd=%0b, expected 1 0", busy, score_upd);
    end
    repeat (5) @(negedge clk);
    tests_run++;
    if (score_upd !== 1'b1 || score !== 24'd140 || lines_total !== 16'd3) begin
      tests_failed++;
      $display("FAIL b2b_second: upd=%0b score=%0d total=%0d, expected 1 140 3", score_upd, score, lines_total);
    end
    exp_score = 140; exp_total = 3; exp_level = 0; exp_lil = 3;
  endtask

  task automatic test_level_max();
    do_new_game();
    lc_pulses = 0;
    for (int i = 0; i < 45; i++) do_event(4, 1'b0);
    tests_run++;
    if (level !== 4'd15 || lc_pulses != 15 || lines_total !== 16'd180) begin
      tests_failed++;
      $display("FAIL level_max: level=%0d pulses=%0d total=%0d, expected 15 15 180", level, lc_pulses, lines_total);
    end
  endtask

  task automatic test_saturate();
    int guard;
    guard = 0;
    while (exp_score != SCORE_MAX && guard < 1000) begin
      do_event(4, 1'b0);
      guard++;
    end
    do_event(4, 1'b1);
    tests_run++;
    if (score !== 24'hFFFFFF || level !== 4'd15) begin
      tests_failed++;
      $display("FAIL score_saturate: score=%0d level=%0d, expected %0d 15", score, level, SCORE_MAX);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_level_up();
    test_ignored();
    test_clamp();
    test_new_game();
    test_reset_mid();
    test_back_to_back();
    test_level_max();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
